// File: rtl/store_merge_unit_pkg.sv
// store_merge_unit_pkg: shared store-size encodings, controller state encoding
// and the alignment rule used by the store merge engine.
package store_merge_unit_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // Halves need an even offset, words a 4-byte aligned one; the reserved
    // size is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off_lo);
        return (size == SIZE_RSVD)
            || (size == SIZE_HALF && off_lo[0])
            || (size == SIZE_WORD && off_lo != 2'b00);
    endfunction

endpackage

// File: rtl/store_merge_unit_byte_lane_merge.sv
// byte_lane_merge: places right-justified store data into the byte lanes of a
// memory word starting at lane off; all other lanes keep old_word.
//   old_word in  DATA_W  word read from memory
//   data     in  DATA_W  right-justified store data
//   size     in  2       store size (word/byte/half)
//   off      in  OFF_W   starting byte lane
//   merged   out DATA_W  merged word
module byte_lane_merge #(
    parameter int DATA_W = 32,
    localparam int LANES = DATA_W / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic [OFF_W-1:0]  off,
    output logic [DATA_W-1:0] merged
);
    import store_merge_unit_pkg::*;

    logic [2:0] nbytes;

    assign nbytes = size == SIZE_BYTE ? 3'd1 : size == SIZE_HALF ? 3'd2 : 3'd4;

    // k is the source byte for lane l; for lanes below off the subtraction
    // wraps to at least LANES-off, which an aligned access never reaches.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [OFF_W-1:0] k;
        assign k = OFF_W'(l) - off;
        assign merged[l*8 +: 8] = 32'(k) < 32'(nbytes) ? data[k*8 +: 8] : old_word[l*8 +: 8];
    end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: store request engine performing read-modify-write with
// byte-lane placement, misalignment rejection and completion signalling.
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_addr/size/data     byte address, size code, right-justified data
//   mem_addr               word-aligned memory address
//   mem_rd/mem_wr          one-cycle read/write strobes
//   mem_wdata/mem_rdata    memory write/read data
//   done                   pulse: store committed
//   misaligned             pulse: request rejected without memory access
module store_merge_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              misaligned
);
    import store_merge_unit_pkg::*;

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t            state;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] merged;

    byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word(mem_rdata),
        .data    (data_q),
        .size    (size_q),
        .off     (off_q),
        .merged  (merged)
    );

    // Outputs are set on the edge that enters the state they belong to, so
    // every output is a plain register decoded from no logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            size_q     <= '0;
            off_q      <= '0;
            data_q     <= '0;
            cnt        <= '0;
        end else begin
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    size_q    <= req_size;
                    off_q     <= req_addr[OFF_W-1:0];
                    data_q    <= req_data;
                    mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state      <= ST_ERR;
                        misaligned <= 1'b1;
                    end else if (req_size == SIZE_WORD && DATA_W == 32) begin
                        // Whole-word store: nothing to preserve, skip the read.
                        state     <= ST_WRITE;
                        mem_wr    <= 1'b1;
                        mem_wdata <= req_data;
                    end else begin
                        state  <= ST_READ;
                        mem_rd <= 1'b1;
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT;
                    cnt   <= CNT_W'(RD_LAT);
                end
                ST_WAIT: if (cnt == CNT_W'(1)) begin
                    state     <= ST_WRITE;
                    mem_wr    <= 1'b1;
                    mem_wdata <= merged;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                ST_WRITE: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed self-checking bench for store_merge_unit,
// one 32-bit RD_LAT=1 instance and one 64-bit RD_LAT=3 instance.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_data = '0;
    logic        req_ready, mem_rd, mem_wr, done, misaligned;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem_val = '0;
    logic        rd_d;

    logic        req_valid_w = 1'b0;
    logic [31:0] req_addr_w = '0;
    logic [1:0]  req_size_w = '0;
    logic [63:0] req_data_w = '0;
    logic        req_ready_w, mem_rd_w, mem_wr_w, done_w, misaligned_w;
    logic [31:0] mem_addr_w;
    logic [63:0] mem_wdata_w, mem_rdata_w;
    logic [63:0] mem_val_w = '0;
    logic [2:0]  rd_p;

    int          vectors = 0;
    int          errors = 0;

    int          cyc, n_rd, n_wr, t_rd, t_done, t_mis, t_rdy, n_both;
    int          t_wr[2];
    logic [31:0] wd[2];
    logic [31:0] wa[2];
    int          n_rd_w, n_wr_w, t_wr_w, t_done_w;
    logic [63:0] wd_w;
    logic [31:0] wa_w;

    always #5 clk = ~clk;

    store_merge_unit dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .done(done), .misaligned(misaligned)
    );

    store_merge_unit #(.DATA_W(64), .RD_LAT(3)) dut_w (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_w), .req_ready(req_ready_w),
        .req_addr(req_addr_w), .req_size(req_size_w), .req_data(req_data_w),
        .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_wr(mem_wr_w),
        .mem_wdata(mem_wdata_w), .mem_rdata(mem_rdata_w),
        .done(done_w), .misaligned(misaligned_w)
    );

    // Memory models return the word only in the cycle RD_LAT after the read
    // strobe and garbage otherwise.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rd_d <= 1'b0;
            rd_p <= '0;
        end else begin
            rd_d <= mem_rd;
            rd_p <= {rd_p[1:0], mem_rd_w};
        end

    assign mem_rdata   = rd_d ? mem_val : 32'hBAD0BAD0;
    assign mem_rdata_w = rd_p[2] ? mem_val_w : 64'hBAD0BAD0BAD0BAD0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        cyc = 0; n_rd = 0; n_wr = 0; t_rd = -1; t_done = -1; t_mis = -1; t_rdy = -1;
        t_wr[0] = -1; t_wr[1] = -1; wd[0] = '0; wd[1] = '0; wa[0] = '0; wa[1] = '0;
        n_rd_w = 0; n_wr_w = 0; t_wr_w = -1; t_done_w = -1; wd_w = '0; wa_w = '0;
    endtask

    // Advances to the next falling edge; cycle cyc=k is the cycle after edge t(k-1).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mem_rd) begin n_rd++; if (t_rd < 0) t_rd = cyc; end
        if (mem_wr) begin
            if (n_wr < 2) begin t_wr[n_wr] = cyc; wd[n_wr] = mem_wdata; wa[n_wr] = mem_addr; end
            n_wr++;
        end
        if (done && t_done < 0) t_done = cyc;
        if (misaligned && t_mis < 0) t_mis = cyc;
        if (req_ready && t_rdy < 0) t_rdy = cyc;
        if (done && misaligned) n_both++;
        if (mem_rd_w) n_rd_w++;
        if (mem_wr_w) begin n_wr_w++; t_wr_w = cyc; wd_w = mem_wdata_w; wa_w = mem_addr_w; end
        if (done_w && t_done_w < 0) t_done_w = cyc;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input int n);
        clear();
        req_valid = 1'b1; req_addr = a; req_size = s; req_data = d;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_size = 2'b11; req_data = 32'hFFFF_FFFF;
        repeat (n - 1) tick();
    endtask

    task automatic store_w(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d, input int n);
        clear();
        req_valid_w = 1'b1; req_addr_w = a; req_size_w = s; req_data_w = d;
        tick();
        req_valid_w = 1'b0; req_data_w = '1;
        repeat (n - 1) tick();
    endtask

    initial begin
        n_both = 0;
        clear();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_strobes", 64'({mem_rd, mem_wr, done, misaligned}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        mem_val = 32'h11223344;
        store(32'h1002, 2'b01, 32'hAABBCC5A, 6);
        check("byte_nrd", 64'(n_rd), 64'd1);
        check("byte_trd", 64'(t_rd), 64'd1);
        check("byte_nwr", 64'(n_wr), 64'd1);
        check("byte_twr", 64'(t_wr[0]), 64'd3);
        check("byte_wdata", 64'(wd[0]), 64'h115A3344);
        check("byte_waddr", 64'(wa[0]), 64'h1000);
        check("byte_done", 64'(t_done), 64'd4);
        check("byte_ready", 64'(t_rdy), 64'd5);

        store(32'h7003, 2'b01, 32'h00000099, 6);
        check("byte3_wdata", 64'(wd[0]), 64'h99223344);
        check("byte3_waddr", 64'(wa[0]), 64'h7000);

        mem_val = 32'hDEADC0DE;
        store(32'h2002, 2'b10, 32'h0000BEEF, 6);
        check("half_wdata", 64'(wd[0]), 64'hBEEFC0DE);
        check("half_waddr", 64'(wa[0]), 64'h2000);
        check("half_done", 64'(t_done), 64'd4);

        store(32'h2001, 2'b10, 32'h0000BEEF, 4);
        check("half_mis", 64'(t_mis), 64'd1);
        check("half_mis_strobes", 64'(n_rd + n_wr), 64'd0);
        check("half_mis_done", 64'(t_done), 64'hFFFF_FFFF_FFFF_FFFF);
        check("half_mis_ready", 64'(t_rdy), 64'd2);

        store(32'h3002, 2'b00, 32'h12345678, 4);
        check("word_mis", 64'(t_mis), 64'd1);
        store(32'h3000, 2'b11, 32'h12345678, 4);
        check("rsvd_mis", 64'(t_mis), 64'd1);
        check("rsvd_strobes", 64'(n_rd + n_wr), 64'd0);

        store(32'h3000, 2'b00, 32'h12345678, 4);
        check("word_nrd", 64'(n_rd), 64'd0);
        check("word_twr", 64'(t_wr[0]), 64'd1);
        check("word_wdata", 64'(wd[0]), 64'h12345678);
        check("word_done", 64'(t_done), 64'd2);
        check("word_ready", 64'(t_rdy), 64'd3);

        mem_val = 32'h0;
        clear();
        req_valid = 1'b1; req_addr = 32'h1001; req_size = 2'b01; req_data = 32'h00000077;
        tick();
        req_addr = 32'h5000; req_size = 2'b00; req_data = 32'hFFFFFFFF;
        repeat (4) tick();
        check("busy_ready", 64'(t_rdy), 64'd5);
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("busy_nwr", 64'(n_wr), 64'd2);
        check("busy_nrd", 64'(n_rd), 64'd1);
        check("busy_wdata0", 64'(wd[0]), 64'h00007700);
        check("busy_twr0", 64'(t_wr[0]), 64'd3);
        check("busy_wdata1", 64'(wd[1]), 64'hFFFFFFFF);
        check("busy_waddr1", 64'(wa[1]), 64'h5000);
        check("busy_twr1", 64'(t_wr[1]), 64'd6);

        mem_val = 32'h11223344;
        clear();
        req_valid = 1'b1; req_addr = 32'h1002; req_size = 2'b01; req_data = 32'hAABBCC5A;
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("rstmid_ready", 64'(req_ready), 64'd1);
        check("rstmid_strobes", 64'({mem_rd, mem_wr, done, misaligned}), 64'd0);
        check("rstmid_addr", 64'(mem_addr), 64'd0);
        check("rstmid_wdata", 64'(mem_wdata), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("rstmid_nwr", 64'(n_wr), 64'd0);
        store(32'h6000, 2'b00, 32'hA5A5A5A5, 4);
        check("rstmid_next_wdata", 64'(wd[0]), 64'hA5A5A5A5);
        check("rstmid_next_done", 64'(t_done), 64'd2);

        mem_val_w = 64'h0123456789ABCDEF;
        store_w(32'h4004, 2'b00, 64'hCAFEF00D, 8);
        check("w64_nrd", 64'(n_rd_w), 64'd1);
        check("w64_nwr", 64'(n_wr_w), 64'd1);
        check("w64_twr", 64'(t_wr_w), 64'd5);
        check("w64_wdata", wd_w, 64'hCAFEF00D89ABCDEF);
        check("w64_waddr", 64'(wa_w), 64'h4000);
        check("w64_done", 64'(t_done_w), 64'd6);

        store_w(32'h0106, 2'b10, 64'h1234, 8);
        check("h64_wdata", wd_w, 64'h1234456789ABCDEF);
        check("h64_waddr", 64'(wa_w), 64'h0100);

        check("done_mis_overlap", 64'(n_both), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Parametrised store-size/merge engine for the multicycle datapath; successor to the combinational byte/half/word store selector. Accepts a store request (address, size, register data), performs the memory read-modify-write itself with byte-lane placement at any aligned offset, flags misaligned accesses, and signals completion to the control unit. Sits between the B register / ALUOut and the memory port, replacing the memory-data-register feedback path for stores.

## Interface
- DATA_W, 32: memory word width; multiple of 8, ≥32; LANES = DATA_W/8, OFF_W = log2(LANES).
- ADDR_W, 32: byte address width.
- RD_LAT, 1: cycles from the `mem_rd` cycle to valid `mem_rdata`; ≥1.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle, request accepted on `req_valid && req_ready`.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 word (32 bit), 01 byte, 10 half, 11 reserved.
- req_data  in  DATA_W  store data, right-justified (B register value).
- mem_addr  out  ADDR_W  word address: `req_addr` with low OFF_W bits cleared.
- mem_rd  out  1  read strobe, one cycle.
- mem_wr  out  1  write strobe, one cycle.
- mem_wdata  out  DATA_W  merged word.
- mem_rdata  in  DATA_W  read data.
- done  out  1  one-cycle pulse, store committed.
- misaligned  out  1  one-cycle pulse, request rejected, no memory access.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE: `req_ready`=1. On accept, latch addr/size/data; off = addr[OFF_W-1:0].
  - misaligned (size 10 and off[0]≠0; size 00 and off[1:0]≠0; size 11) -> ERR.
  - full-width (size 00 and DATA_W=32) -> WRITE, `mem_wdata` = req_data.
  - otherwise -> READ.
- READ: `mem_rd`=1 one cycle -> WAIT; counter loaded with RD_LAT.
- WAIT: count down; on last cycle capture `mem_rdata`, merge -> WRITE.
- Merge: byte -> req_data[7:0] into lane off; half -> req_data[15:0] into lanes off, off+1; word (DATA_W>32) -> req_data[31:0] into lanes off..off+3; all other lanes keep captured read data.
- WRITE: `mem_wr`=1 one cycle, `mem_wdata` = merged word -> DONE.
- DONE: `done`=1 -> IDLE. ERR: `misaligned`=1 -> IDLE.
- `mem_addr` held stable from READ through WRITE.

## Timing
- All outputs registered (Moore). Reset values: `req_ready`=1; all other outputs 0; state IDLE.
- Partial store: accept edge t0; READ t1; WAIT t2..t1+RD_LAT; WRITE t2+RD_LAT; DONE t3+RD_LAT; ready t4+RD_LAT. RD_LAT=1: 5 cycles accept-to-ready.
- Full-width store: WRITE t1, DONE t2, ready t3.
- Misaligned: ERR t1, ready t2; `mem_rd`/`mem_wr` never asserted.
- `req_valid` while `req_ready`=0 ignored; no queueing; request inputs sampled only at accept.
- `mem_rdata` sampled only on final WAIT cycle; other values ignored.
- Reset mid-operation: strobes drop immediately (asynchronous), no partial write, pending request discarded.
- `done` and `misaligned` never high together.

## Structure
- Shared package: size encodings (SIZE_WORD=00, SIZE_BYTE=01, SIZE_HALF=10), state encoding, misalignment function.
- One sub-module: `byte_lane_merge` (combinational; DATA_W param; inputs old word, data, size, off; output merged word), reusable by future load-extend logic.
- RD_LAT counter width = clog2(RD_LAT+1).

## Test plan
- Byte store, DATA_W=32, addr 0x1002, data 0xAABBCC5A, mem 0x11223344 -> one `mem_rd`, one `mem_wr` of 0x115A3344 to 0x1000, `done` at t4.
- Half store addr 0x2002, data 0x0000BEEF, mem 0xDEADC0DE -> write 0xBEEFC0DE; addr 0x2001 -> `misaligned` at t1, no strobes.
- Word store addr 0x3000, data 0x12345678 (DATA_W=32) -> no read, `mem_wr` at t1 with 0x12345678, `done` at t2.
- DATA_W=64, RD_LAT=3, word store addr 0x4004, data 0xCAFEF00D, mem 0x0123456789ABCDEF -> write 0xCAFEF00D89ABCDEF, `done` at t6.
- `req_valid` held high during busy with different data -> only first request performed; second accepted after `req_ready` returns.
- `reset_n` pulsed low during WAIT -> no `mem_wr`, all outputs at reset values, next request completes normally.
